// File: rtl/fwd_hazard_unit_if.sv
// Decode-to-execute control bus: D-stage instruction fields and pipeline controls in,
// load-use stall and registered execute-stage operand selects out.
interface fwd_hazard_unit_if #(
   parameter int REG_ADDR_W = 5
);
   // Handshake: d_valid qualifies every d_* field in the same cycle. stall is the
   // not-ready back-pressure, so the D instruction is accepted into X at a rising edge
   // only when d_valid & !stall & !flush & !hold. Otherwise the requester keeps the
   // instruction stable and X receives a bubble (or holds, when hold is high).
   logic                  d_valid;
   logic [REG_ADDR_W-1:0] d_rs1;
   logic [REG_ADDR_W-1:0] d_rs2;
   logic [REG_ADDR_W-1:0] d_rd;
   logic                  d_uses_rs1;
   logic                  d_uses_rs2;
   logic                  d_reg_write;
   logic                  d_is_load;
   logic                  d_op1_is_pc;
   logic                  d_op2_is_imm;
   logic                  hold;
   logic                  flush;
   logic                  stall;
   logic [1:0]            operand1_sel;
   logic [1:0]            operand2_sel;
   logic [1:0]            rs2_data_sel;

   modport master (
      output d_valid, d_rs1, d_rs2, d_rd, d_uses_rs1, d_uses_rs2,
             d_reg_write, d_is_load, d_op1_is_pc, d_op2_is_imm, hold, flush,
      input  stall, operand1_sel, operand2_sel, rs2_data_sel
   );

   modport slave (
      input  d_valid, d_rs1, d_rs2, d_rd, d_uses_rs1, d_uses_rs2,
             d_reg_write, d_is_load, d_op1_is_pc, d_op2_is_imm, hold, flush,
      output stall, operand1_sel, operand2_sel, rs2_data_sel
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation for a five-stage RV32 pipeline.
// Tracks the destination of the X and M instructions and compares it with D's sources.
module fwd_hazard_unit #(
   parameter int REG_ADDR_W = 5,
   parameter bit FWD_EN     = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   fwd_hazard_unit_if.slave  bus
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  wen;
      logic                  load;
   } entry_t;

   localparam logic [1:0] SEL_REG = 2'b00;
   localparam logic [1:0] SEL_ALT = 2'b01;
   localparam logic [1:0] SEL_XM  = 2'b10;
   localparam logic [1:0] SEL_MW  = 2'b11;

   entry_t     x_q;
   entry_t     m_q;
   entry_t     d_entry;
   logic [1:0] op1_q;
   logic [1:0] op2_q;
   logic [1:0] rs2d_q;

   logic       x_hit1;
   logic       x_hit2;
   logic       m_hit1;
   logic       m_hit2;
   logic       hazard;
   logic       stall_c;
   logic       accept;
   logic [1:0] src1_sel;
   logic [1:0] src2_sel;
   logic [1:0] op1_next;
   logic [1:0] op2_next;

   // x0 is hard-wired zero, so a producer writing it never creates a dependency.
   function automatic logic producer_match(input entry_t e, input logic [REG_ADDR_W-1:0] r);
      return e.valid && e.wen && (e.rd != '0) && (r == e.rd);
   endfunction

   function automatic logic [1:0] source_sel(input logic xh, input logic mh);
      logic [1:0] s;
      s = SEL_REG;
      if (FWD_EN) begin
         if (xh) begin
            s = SEL_XM;
         end else if (mh) begin
            s = SEL_MW;
         end
      end
      return s;
   endfunction

   always_comb begin
      x_hit1 = bus.d_uses_rs1 & producer_match(x_q, bus.d_rs1);
      x_hit2 = bus.d_uses_rs2 & producer_match(x_q, bus.d_rs2);
      m_hit1 = bus.d_uses_rs1 & producer_match(m_q, bus.d_rs1);
      m_hit2 = bus.d_uses_rs2 & producer_match(m_q, bus.d_rs2);
   end

   // With forwarding only a load in X cannot supply its result in time.
   always_comb begin
      hazard = 1'b0;
      if (FWD_EN) begin
         hazard = x_q.load & (x_hit1 | x_hit2);
      end else begin
         hazard = x_hit1 | x_hit2 | m_hit1 | m_hit2;
      end
   end

   assign stall_c = bus.d_valid & ~bus.flush & hazard;
   assign accept  = bus.d_valid & ~stall_c & ~bus.flush;

   always_comb begin
      src1_sel = source_sel(x_hit1, m_hit1);
      src2_sel = source_sel(x_hit2, m_hit2);
      op1_next = bus.d_op1_is_pc  ? SEL_ALT : src1_sel;
      op2_next = bus.d_op2_is_imm ? SEL_ALT : src2_sel;
   end

   always_comb begin
      d_entry       = '0;
      d_entry.valid = 1'b1;
      d_entry.rd    = bus.d_rd;
      d_entry.wen   = bus.d_reg_write;
      d_entry.load  = bus.d_is_load;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q    <= '0;
         m_q    <= '0;
         op1_q  <= SEL_REG;
         op2_q  <= SEL_REG;
         rs2d_q <= SEL_REG;
      end else if (!bus.hold) begin
         m_q <= x_q;
         if (accept) begin
            x_q    <= d_entry;
            op1_q  <= op1_next;
            op2_q  <= op2_next;
            rs2d_q <= src2_sel;
         end else begin
            x_q    <= '0;
            op1_q  <= SEL_REG;
            op2_q  <= SEL_REG;
            rs2d_q <= SEL_REG;
         end
      end
   end

   assign bus.stall        = stall_c;
   assign bus.operand1_sel = op1_q;
   assign bus.operand2_sel = op2_q;
   assign bus.rs2_data_sel = rs2d_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: one forwarding and one non-forwarding instance share the
// same D-stage stimulus and are checked every cycle against a pipeline model.
module tb_fwd_hazard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       d_valid;
   logic [4:0] d_rs1, d_rs2, d_rd;
   logic       d_uses_rs1, d_uses_rs2, d_reg_write, d_is_load;
   logic       d_op1_is_pc, d_op2_is_imm;
   logic       hold, flush;

   always #5 clk = ~clk;

   fwd_hazard_unit_if #(.REG_ADDR_W(5)) bus_f ();
   fwd_hazard_unit_if #(.REG_ADDR_W(5)) bus_n ();

   assign bus_f.d_valid      = d_valid;
   assign bus_f.d_rs1        = d_rs1;
   assign bus_f.d_rs2        = d_rs2;
   assign bus_f.d_rd         = d_rd;
   assign bus_f.d_uses_rs1   = d_uses_rs1;
   assign bus_f.d_uses_rs2   = d_uses_rs2;
   assign bus_f.d_reg_write  = d_reg_write;
   assign bus_f.d_is_load    = d_is_load;
   assign bus_f.d_op1_is_pc  = d_op1_is_pc;
   assign bus_f.d_op2_is_imm = d_op2_is_imm;
   assign bus_f.hold         = hold;
   assign bus_f.flush        = flush;

   assign bus_n.d_valid      = d_valid;
   assign bus_n.d_rs1        = d_rs1;
   assign bus_n.d_rs2        = d_rs2;
   assign bus_n.d_rd         = d_rd;
   assign bus_n.d_uses_rs1   = d_uses_rs1;
   assign bus_n.d_uses_rs2   = d_uses_rs2;
   assign bus_n.d_reg_write  = d_reg_write;
   assign bus_n.d_is_load    = d_is_load;
   assign bus_n.d_op1_is_pc  = d_op1_is_pc;
   assign bus_n.d_op2_is_imm = d_op2_is_imm;
   assign bus_n.hold         = hold;
   assign bus_n.flush        = flush;

   fwd_hazard_unit #(.REG_ADDR_W(5), .FWD_EN(1'b1)) dut_f (.clk(clk), .rst(rst), .bus(bus_f));
   fwd_hazard_unit #(.REG_ADDR_W(5), .FWD_EN(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

   int errors = 0;
   int checks = 0;

   // Model: index 0 is the forwarding pipeline, index 1 the non-forwarding one.
   typedef struct {
      bit v;
      int rd;
      bit wen;
      bit ld;
   } ent_t;

   ent_t mx[2];
   ent_t mm[2];
   int   e1[2], e2[2], e3[2];
   bit   last_st[2];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit hits(ent_t e, int r);
      return e.v && e.wen && (e.rd != 0) && (e.rd == r);
   endfunction

   // Producers listed youngest first; the first one that writes r supplies the operand.
   function automatic int src_code(int k, bit used, int r);
      ent_t prod[2];
      if (!used || k == 1) return 0;
      prod[0] = mx[k];
      prod[1] = mm[k];
      for (int i = 0; i < 2; i++) begin
         if (hits(prod[i], r)) return 2 + i;
      end
      return 0;
   endfunction

   function automatic bit model_stall(int k);
      bit haz;
      int rs[2];
      bit u[2];
      haz   = 1'b0;
      rs[0] = int'(d_rs1);
      rs[1] = int'(d_rs2);
      u[0]  = d_uses_rs1;
      u[1]  = d_uses_rs2;
      for (int j = 0; j < 2; j++) begin
         if (u[j]) begin
            if (k == 0) haz = haz | (mx[k].ld && hits(mx[k], rs[j]));
            else        haz = haz | hits(mx[k], rs[j]) | hits(mm[k], rs[j]);
         end
      end
      return d_valid && !flush && haz;
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < 2; k++) begin
         mx[k] = '{0, 0, 0, 0};
         mm[k] = '{0, 0, 0, 0};
         e1[k] = 0;
         e2[k] = 0;
         e3[k] = 0;
      end
   endfunction

   task automatic model_edge();
      bit   st;
      int   n1, n2, n3;
      ent_t nx;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            mx[k] = '{0, 0, 0, 0};
            mm[k] = '{0, 0, 0, 0};
            e1[k] = 0; e2[k] = 0; e3[k] = 0;
         end else if (!hold) begin
            st = model_stall(k);
            nx = '{0, 0, 0, 0};
            n1 = 0; n2 = 0; n3 = 0;
            if (d_valid && !st && !flush) begin
               n3 = src_code(k, d_uses_rs2, int'(d_rs2));
               n1 = d_op1_is_pc  ? 1 : src_code(k, d_uses_rs1, int'(d_rs1));
               n2 = d_op2_is_imm ? 1 : n3;
               nx = '{1, int'(d_rd), d_reg_write, d_is_load};
            end
            mm[k] = mx[k];
            mx[k] = nx;
            e1[k] = n1; e2[k] = n2; e3[k] = n3;
         end
      end
   endtask

   task automatic compare();
      int s[2], o1[2], o2[2], r2[2];
      s[0]  = bus_f.stall;        s[1]  = bus_n.stall;
      o1[0] = bus_f.operand1_sel; o1[1] = bus_n.operand1_sel;
      o2[0] = bus_f.operand2_sel; o2[1] = bus_n.operand2_sel;
      r2[0] = bus_f.rs2_data_sel; r2[1] = bus_n.rs2_data_sel;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("stall[%0d]", k), s[k], int'(model_stall(k)));
         chk($sformatf("operand1_sel[%0d]", k), o1[k], e1[k]);
         chk($sformatf("operand2_sel[%0d]", k), o2[k], e2[k]);
         chk($sformatf("rs2_data_sel[%0d]", k), r2[k], e3[k]);
         last_st[k] = s[k][0];
      end
   endtask

   // Inputs are applied 1 ns after a rising edge; outputs are checked on the falling edge.
   task automatic step();
      @(negedge clk);
      compare();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ins(input bit v, input int rs1, input int rs2, input int rd,
                          input bit u1, input bit u2, input bit w, input bit ld,
                          input bit pc, input bit imm);
      d_valid      = v;
      d_rs1        = 5'(rs1);
      d_rs2        = 5'(rs2);
      d_rd         = 5'(rd);
      d_uses_rs1   = u1;
      d_uses_rs2   = u2;
      d_reg_write  = w;
      d_is_load    = ld;
      d_op1_is_pc  = pc;
      d_op2_is_imm = imm;
   endtask

   task automatic alu(input int rd, input int a, input int b);
      set_ins(1, a, b, rd, 1, 1, 1, 0, 0, 0);
   endtask
   task automatic addi(input int rd, input int a);
      set_ins(1, a, 0, rd, 1, 0, 1, 0, 0, 1);
   endtask
   task automatic lw(input int rd, input int a);
      set_ins(1, a, 0, rd, 1, 0, 1, 1, 0, 1);
   endtask
   task automatic sw(input int base, input int src);
      set_ins(1, base, src, 0, 1, 1, 0, 0, 0, 1);
   endtask

   task automatic lit_sels(input string name, input int o1, input int o2, input int r2);
      chk({name, ".op1"}, int'(bus_f.operand1_sel), o1);
      chk({name, ".op2"}, int'(bus_f.operand2_sel), o2);
      chk({name, ".rs2d"}, int'(bus_f.rs2_data_sel), r2);
      chk({name, ".model_op1"}, e1[0], o1);
   endtask

   initial begin
      rst = 1'b1; hold = 1'b0; flush = 1'b0;
      set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_clear();
      @(posedge clk); #1;
      step();
      lit_sels("reset", 0, 0, 0);
      chk("reset.stall", int'(last_st[0]), 0);
      rst = 1'b0;

      // ALU result forwarded from X
      alu(5, 1, 2);  step();
      alu(6, 5, 7);  step();
      chk("xm_fwd.stall", int'(last_st[0]), 0);
      lit_sels("xm_fwd", 2, 0, 0);

      // load-use: one stall then M_W forward
      lw(5, 1);      step();
      alu(6, 7, 5);  step();
      chk("load_use.stall", int'(last_st[0]), 1);
      lit_sels("load_use.bubble", 0, 0, 0);
      step();
      chk("load_use.restall", int'(last_st[0]), 0);
      lit_sels("load_use.mw", 0, 3, 3);

      // x0 producers never match
      addi(0, 1);    step();
      alu(8, 0, 0);  step();
      lit_sels("x0_alu", 0, 0, 0);
      lw(0, 1);      step();
      alu(9, 0, 3);  step();
      chk("x0_load.stall", int'(last_st[0]), 0);

      // youngest producer wins; store data from M
      alu(5, 1, 2);  step();
      alu(5, 3, 4);  step();
      alu(10, 5, 5); step();
      lit_sels("x_wins", 2, 2, 2);
      alu(5, 1, 2);  step();
      alu(11, 1, 2); step();
      sw(8, 5);      step();
      lit_sels("store_mw", 0, 1, 3);

      // hold freezes a pending load-use
      lw(5, 1);      step();
      alu(6, 5, 7);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("hold%0d.stall", i), int'(last_st[0]), 1);
         lit_sels($sformatf("hold%0d", i), 0, 1, 0);
      end
      hold = 1'b0;
      step();
      chk("hold_release.stall", int'(last_st[0]), 1);
      step();
      lit_sels("hold_after", 3, 0, 0);

      // flush turns D into a bubble and suppresses stall
      lw(5, 1);      step();
      alu(6, 5, 7);  flush = 1'b1; step();
      chk("flush.stall", int'(last_st[0]), 0);
      lit_sels("flush", 0, 0, 0);
      flush = 1'b0;

      // reset in the middle of a load-use stall
      lw(5, 1);      step();
      alu(6, 5, 7);  rst = 1'b1; step();
      chk("rst_mid.stall_before", int'(last_st[0]), 1);
      lit_sels("rst_mid", 0, 0, 0);
      rst = 1'b0;    step();
      chk("rst_mid.stall_after", int'(last_st[0]), 0);

      // no-forwarding instance: two stall cycles then plain register read
      rst = 1'b1;    step();
      rst = 1'b0;
      alu(5, 1, 2);  step();
      alu(6, 5, 7);
      step(); chk("nofwd.stall0", int'(last_st[1]), 1);
      step(); chk("nofwd.stall1", int'(last_st[1]), 1);
      step(); chk("nofwd.stall2", int'(last_st[1]), 0);
      chk("nofwd.op1", int'(bus_n.operand1_sel), 0);

      // mixed sweep over a small register set to provoke many dependencies
      for (int n = 0; n < 400; n++) begin
         set_ins($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
         hold  = ($urandom_range(0, 5) == 0);
         flush = ($urandom_range(0, 6) == 0);
         rst   = ($urandom_range(0, 60) == 0);
         step();
      end
      rst = 1'b0; hold = 1'b0; flush = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
